// File: rtl/frog_ctrl.sv
// Frog player controller: hop animation, field limits, collision/death handling,
// lives and crossing score. Everything advances once per video frame.
module frog_ctrl #(
  parameter logic [10:0] START_X      = 11'd300,
  parameter logic [10:0] START_Y      = 11'd440,
  parameter logic [10:0] STEP         = 11'd40,
  parameter int          HOP_FRAMES   = 4,
  parameter int          DEATH_FRAMES = 30,
  parameter logic [2:0]  INIT_LIVES   = 3'd3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        Car_Collision,
  output logic [10:0] Frog_X,
  output logic [10:0] Frog_Y,
  output logic [2:0]  Lives,
  output logic [7:0]  Score,
  output logic        Frog_Dead,
  output logic        Game_Over
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOP  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [10:0] X_MAX = 11'd600;
  localparam logic [10:0] Y_MAX = 11'd440;

  localparam int          HOP_STEP_I = int'(STEP) / HOP_FRAMES;
  localparam logic [10:0] HOP_STEP   = 11'(HOP_STEP_I);
  localparam int          HCW        = $clog2(HOP_FRAMES + 1);
  localparam int          DCW        = $clog2(DEATH_FRAMES + 1);

  logic [1:0]     state_reg, state_next;
  logic [1:0]     dir_reg, dir_next;
  logic [10:0]    x_reg, x_next;
  logic [10:0]    y_reg, y_next;
  logic [2:0]     lives_reg, lives_next;
  logic [7:0]     score_reg, score_next;
  logic [7:0]     key_prev_reg;
  logic [HCW-1:0] hop_cnt_reg, hop_cnt_next;
  logic [DCW-1:0] death_cnt_reg, death_cnt_next;

  logic        key_is_dir;
  logic [1:0]  key_dir;
  logic        press_valid;
  logic        target_ok;
  logic        do_step;
  logic        last_step;
  logic [1:0]  step_dir;
  logic [10:0] step_x, step_y;

  function automatic logic [21:0] step_pos(input logic [1:0] d,
                                           input logic [10:0] x,
                                           input logic [10:0] y);
    logic [10:0] nx;
    logic [10:0] ny;
    nx = x;
    ny = y;
    case (d)
      DIR_UP:    ny = y - HOP_STEP;
      DIR_DOWN:  ny = y + HOP_STEP;
      DIR_LEFT:  nx = x - HOP_STEP;
      default:   nx = x + HOP_STEP;
    endcase
    return {nx, ny};
  endfunction

  always_comb begin
    key_is_dir = 1'b1;
    key_dir    = DIR_UP;
    case (keycode)
      KEY_W:   key_dir = DIR_UP;
      KEY_S:   key_dir = DIR_DOWN;
      KEY_A:   key_dir = DIR_LEFT;
      KEY_D:   key_dir = DIR_RIGHT;
      default: key_is_dir = 1'b0;
    endcase
    press_valid = key_is_dir && (keycode != key_prev_reg);

    // The whole hop must land inside the field, not just the first step.
    case (key_dir)
      DIR_UP:   target_ok = (y_reg >= STEP);
      DIR_DOWN: target_ok = (y_reg <= Y_MAX - STEP);
      DIR_LEFT: target_ok = (x_reg >= STEP);
      default:  target_ok = (x_reg <= X_MAX - STEP);
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    dir_next       = dir_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    lives_next     = lives_reg;
    score_next     = score_reg;
    hop_cnt_next   = hop_cnt_reg;
    death_cnt_next = death_cnt_reg;
    do_step        = 1'b0;
    last_step      = 1'b0;
    step_dir       = dir_reg;
    step_x         = x_reg;
    step_y         = y_reg;

    case (state_reg)
      ST_IDLE, ST_HOP: begin
        if (Car_Collision) begin
          state_next     = ST_DEAD;
          hop_cnt_next   = '0;
          death_cnt_next = '0;
          lives_next     = (lives_reg != 3'd0) ? lives_reg - 3'd1 : 3'd0;
        end else if (state_reg == ST_HOP) begin
          do_step   = 1'b1;
          step_dir  = dir_reg;
          last_step = (hop_cnt_reg == HCW'(HOP_FRAMES - 1));
        end else if (press_valid && target_ok) begin
          do_step   = 1'b1;
          step_dir  = key_dir;
          dir_next  = key_dir;
          last_step = (HOP_FRAMES == 1);
        end
      end
      ST_DEAD: begin
        if (death_cnt_reg == DCW'(DEATH_FRAMES - 1)) begin
          death_cnt_next = '0;
          if (lives_reg != 3'd0) begin
            state_next = ST_IDLE;
            x_next     = START_X;
            y_next     = START_Y;
          end else begin
            state_next = ST_OVER;
          end
        end else begin
          death_cnt_next = death_cnt_reg + DCW'(1);
        end
      end
      default: ;
    endcase

    if (do_step) begin
      {step_x, step_y} = step_pos(step_dir, x_reg, y_reg);
      x_next       = step_x;
      y_next       = step_y;
      hop_cnt_next = hop_cnt_reg + HCW'(1);
      state_next   = ST_HOP;
      if (last_step) begin
        state_next   = ST_IDLE;
        hop_cnt_next = '0;
        // Reaching the top row completes a crossing and sends the frog home.
        if (step_dir == DIR_UP && step_y == 11'd0) begin
          score_next = (score_reg != 8'hFF) ? score_reg + 8'd1 : score_reg;
          x_next     = START_X;
          y_next     = START_Y;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_reg     <= ST_IDLE;
      dir_reg       <= DIR_UP;
      x_reg         <= START_X;
      y_reg         <= START_Y;
      lives_reg     <= INIT_LIVES;
      score_reg     <= 8'd0;
      key_prev_reg  <= 8'd0;
      hop_cnt_reg   <= '0;
      death_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      dir_reg       <= dir_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      lives_reg     <= lives_next;
      score_reg     <= score_next;
      key_prev_reg  <= keycode;
      hop_cnt_reg   <= hop_cnt_next;
      death_cnt_reg <= death_cnt_next;
    end
  end

  assign Frog_X    = x_reg;
  assign Frog_Y    = y_reg;
  assign Lives     = lives_reg;
  assign Score     = score_reg;
  assign Frog_Dead = (state_reg == ST_DEAD);
  assign Game_Over = (state_reg == ST_OVER);

endmodule

// File: tb/tb_frog_ctrl.sv
// Bench for frog_ctrl: table of frame vectors plus hand-written death, game-over,
// scoring and reset sequences; expected outputs go through a scoreboard queue.
module tb_frog_ctrl;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  keycode = 8'h00;
  logic        Car_Collision = 1'b0;
  logic [10:0] Frog_X, Frog_Y;
  logic [2:0]  Lives;
  logic [7:0]  Score;
  logic        Frog_Dead, Game_Over;

  // Second instance starts on the right edge of the field to probe the X limit.
  logic [10:0] e_x, e_y;
  logic [2:0]  e_lives;
  logic [7:0]  e_score;
  logic        e_dead, e_over;

  frog_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .Car_Collision(Car_Collision), .Frog_X(Frog_X), .Frog_Y(Frog_Y),
    .Lives(Lives), .Score(Score), .Frog_Dead(Frog_Dead), .Game_Over(Game_Over)
  );

  frog_ctrl #(.START_X(11'd600)) dut_edge (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .Car_Collision(Car_Collision), .Frog_X(e_x), .Frog_Y(e_y),
    .Lives(e_lives), .Score(e_score), .Frog_Dead(e_dead), .Game_Over(e_over)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [2:0]  lives;
    logic [7:0]  score;
    logic        dead;
    logic        over;
  } outs_t;

  typedef struct {
    logic [7:0] key;
    logic       coll;
    outs_t      exp;
  } vec_t;

  outs_t sb_q[$];
  vec_t  tbl[16];
  int    total = 0;
  int    passed = 0;

  function automatic outs_t mk(input int x, input int y, input int l,
                               input int s, input int d, input int o);
    outs_t r;
    r.x = 11'(x); r.y = 11'(y); r.lives = 3'(l);
    r.score = 8'(s); r.dead = 1'(d); r.over = 1'(o);
    return r;
  endfunction

  task automatic compare(input string name);
    outs_t exp, act;
    exp = sb_q.pop_front();
    act = '{Frog_X, Frog_Y, Lives, Score, Frog_Dead, Game_Over};
    total++;
    if (act === exp) begin
      passed++;
      $display("ok   %s: x=%0d y=%0d lives=%0d score=%0d dead=%0b over=%0b",
               name, act.x, act.y, act.lives, act.score, act.dead, act.over);
    end else begin
      $display("FAIL %s: got x=%0d y=%0d lives=%0d score=%0d dead=%0b over=%0b, want x=%0d y=%0d lives=%0d score=%0d dead=%0b over=%0b",
               name, act.x, act.y, act.lives, act.score, act.dead, act.over,
               exp.x, exp.y, exp.lives, exp.score, exp.dead, exp.over);
    end
  endtask

  task automatic expect_now(input string name, input outs_t e);
    sb_q.push_back(e);
    compare(name);
  endtask

  task automatic step(input string name, input logic [7:0] k, input logic c,
                      input outs_t e);
    keycode = k;
    Car_Collision = c;
    sb_q.push_back(e);
    @(posedge frame_clk);
    #1;
    compare(name);
  endtask

  task automatic check_edge_x(input string name);
    total++;
    if (e_x === 11'd600) begin
      passed++;
      $display("ok   %s: edge frog x=%0d", name, e_x);
    end else begin
      $display("FAIL %s: edge frog x=%0d, want 600", name, e_x);
    end
  endtask

  initial begin
    // Up hop, idle, then right key held (one hop only), down hop, blocked down.
    tbl[0]  = '{8'h1A, 1'b0, mk(300, 430, 3, 0, 0, 0)};
    tbl[1]  = '{8'h00, 1'b0, mk(300, 420, 3, 0, 0, 0)};
    tbl[2]  = '{8'h00, 1'b0, mk(300, 410, 3, 0, 0, 0)};
    tbl[3]  = '{8'h00, 1'b0, mk(300, 400, 3, 0, 0, 0)};
    tbl[4]  = '{8'h00, 1'b0, mk(300, 400, 3, 0, 0, 0)};
    tbl[5]  = '{8'h07, 1'b0, mk(310, 400, 3, 0, 0, 0)};
    tbl[6]  = '{8'h07, 1'b0, mk(320, 400, 3, 0, 0, 0)};
    tbl[7]  = '{8'h07, 1'b0, mk(330, 400, 3, 0, 0, 0)};
    tbl[8]  = '{8'h07, 1'b0, mk(340, 400, 3, 0, 0, 0)};
    tbl[9]  = '{8'h07, 1'b0, mk(340, 400, 3, 0, 0, 0)};
    tbl[10] = '{8'h00, 1'b0, mk(340, 400, 3, 0, 0, 0)};
    tbl[11] = '{8'h16, 1'b0, mk(340, 410, 3, 0, 0, 0)};
    tbl[12] = '{8'h00, 1'b0, mk(340, 420, 3, 0, 0, 0)};
    tbl[13] = '{8'h00, 1'b0, mk(340, 430, 3, 0, 0, 0)};
    tbl[14] = '{8'h00, 1'b0, mk(340, 440, 3, 0, 0, 0)};
    tbl[15] = '{8'h16, 1'b0, mk(340, 440, 3, 0, 0, 0)};

    #1 Reset = 1'b0;
    #2 expect_now("reset", mk(300, 440, 3, 0, 0, 0));
    #9 Reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), tbl[i].key, tbl[i].coll, tbl[i].exp);
      if (tbl[i].key == 8'h07) check_edge_x($sformatf("xlimit%0d", i));
    end
    for (int i = 0; i < 15; i++) begin
      step($sformatf("held%0d", i), 8'h07, 1'b0, mk(340, 400, 3, 0, 0, 0));
      check_edge_x($sformatf("xlimit_held%0d", i));
    end
    for (int i = 10; i < 16; i++)
      step($sformatf("vec%0d", i), tbl[i].key, tbl[i].coll, tbl[i].exp);

    // Collision on the same edge as a left press: dies in place.
    step("die1", 8'h04, 1'b1, mk(340, 440, 2, 0, 1, 0));
    for (int i = 1; i < 30; i++)
      step($sformatf("dead1_%0d", i), 8'h00, 1'(i % 2), mk(340, 440, 2, 0, 1, 0));
    step("respawn1", 8'h00, 1'b0, mk(300, 440, 2, 0, 0, 0));

    // Collision mid-hop freezes the partial position.
    step("hop2", 8'h1A, 1'b0, mk(300, 430, 2, 0, 0, 0));
    step("die2", 8'h00, 1'b1, mk(300, 430, 1, 0, 1, 0));
    for (int i = 1; i < 30; i++)
      step($sformatf("dead2_%0d", i), 8'h00, 1'b0, mk(300, 430, 1, 0, 1, 0));
    step("respawn2", 8'h00, 1'b0, mk(300, 440, 1, 0, 0, 0));

    // Last life lost: game over after the death period, then nothing moves.
    step("die3", 8'h00, 1'b1, mk(300, 440, 0, 0, 1, 0));
    for (int i = 1; i < 30; i++)
      step($sformatf("dead3_%0d", i), 8'h00, 1'b0, mk(300, 440, 0, 0, 1, 0));
    step("over", 8'h00, 1'b0, mk(300, 440, 0, 0, 0, 1));
    step("over_up", 8'h1A, 1'b0, mk(300, 440, 0, 0, 0, 1));
    step("over_rel", 8'h00, 1'b0, mk(300, 440, 0, 0, 0, 1));
    step("over_right", 8'h07, 1'b1, mk(300, 440, 0, 0, 0, 1));
    step("over_coll", 8'h00, 1'b1, mk(300, 440, 0, 0, 0, 1));

    Reset = 1'b0;
    #2 expect_now("reset_over", mk(300, 440, 3, 0, 0, 0));
    #2 Reset = 1'b1;

    // Eleven up hops; a press during each hop must be ignored.
    for (int h = 0; h < 11; h++) begin
      step($sformatf("up%0d_a", h), 8'h1A, 1'b0, mk(300, 440 - 40*h - 10, 3, 0, 0, 0));
      step($sformatf("up%0d_b", h), 8'h07, 1'b0, mk(300, 440 - 40*h - 20, 3, 0, 0, 0));
      step($sformatf("up%0d_c", h), 8'h00, 1'b0, mk(300, 440 - 40*h - 30, 3, 0, 0, 0));
      if (h == 10)
        step("cross", 8'h00, 1'b0, mk(300, 440, 3, 1, 0, 0));
      else
        step($sformatf("up%0d_d", h), 8'h00, 1'b0, mk(300, 440 - 40*h - 40, 3, 0, 0, 0));
    end

    // Reset in the middle of a hop abandons it.
    step("hop_r", 8'h1A, 1'b0, mk(300, 430, 3, 1, 0, 0));
    Reset = 1'b0;
    #2 expect_now("reset_hop", mk(300, 440, 3, 0, 0, 0));
    step("reset_hold", 8'h00, 1'b0, mk(300, 440, 3, 0, 0, 0));
    #2 Reset = 1'b1;
    step("after_reset", 8'h00, 1'b0, mk(300, 440, 3, 0, 0, 0));
    step("fresh_hop", 8'h1A, 1'b0, mk(300, 430, 3, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
